// File: rtl/inst_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding word
// request to instruction memory, and hands (pc, inst) pairs to decode
// through a one-entry valid/ready buffer. Redirects may arrive in any state.
module inst_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [15:0]       fetch_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              drop;
    logic              drop_next;
    logic [DATA_W-1:0] if_inst_next;
    logic [ADDR_W-1:0] if_pc_next;
    logic [CNT_W-1:0]  count_next;

    // State and datapath registers; reset aborts any in-flight fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            if_inst     <= '0;
            if_pc       <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            drop        <= drop_next;
            if_inst     <= if_inst_next;
            if_pc       <= if_pc_next;
            fetch_count <= count_next;
        end
    end

    // Next-state and datapath update; redirect always reloads the PC
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        drop_next    = drop;
        if_inst_next = if_inst;
        if_pc_next   = if_pc;
        count_next   = fetch_count;
        case (state)
            ST_REQ: begin
                // A handshake coinciding with a redirect is void
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end else if (imem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_next   = redirect_target;
                    drop_next = 1'b1;
                end
                if (imem_resp_valid) begin
                    if (drop || redirect_valid) begin
                        // Response belongs to the abandoned stream
                        drop_next  = 1'b0;
                        state_next = ST_REQ;
                    end else begin
                        if_inst_next = imem_resp_data;
                        if_pc_next   = pc;
                        state_next   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = ST_REQ;
                end else if (if_ready) begin
                    count_next = fetch_count + CNT_W'(1);
                    pc_next    = pc + ADDR_W'(1);
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        imem_req_valid = (state == ST_REQ);
        if_valid       = (state == ST_HOLD);
        imem_addr      = pc;
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: randomized memory/decode/redirect stimulus with a
// transaction-level reference model feeding a scoreboard of expected handoffs.
module tb_inst_fetch_unit;

    localparam int unsigned    AW  = 16;
    localparam int unsigned    DW  = 16;
    localparam logic [AW-1:0]  RPC = 16'h0000;

    logic          clk;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_addr;
    logic          imem_resp_valid;
    logic [DW-1:0] imem_resp_data;
    logic          if_valid;
    logic          if_ready;
    logic [DW-1:0] if_inst;
    logic [AW-1:0] if_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic [15:0]   fetch_count;

    // Second instance exercising PC wrap from a reset value near the top
    logic          w_req_valid;
    logic [AW-1:0] w_addr;
    logic          w_resp_valid;
    logic [DW-1:0] w_resp_data;
    logic          w_if_valid;
    logic [DW-1:0] w_if_inst;
    logic [AW-1:0] w_if_pc;
    logic [15:0]   w_fetch_count;

    inst_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_count     (fetch_count)
    );

    inst_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(16'hFFFE)) u_wrap (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (w_req_valid),
        .imem_req_ready  (1'b1),
        .imem_addr       (w_addr),
        .imem_resp_valid (w_resp_valid),
        .imem_resp_data  (w_resp_data),
        .if_valid        (w_if_valid),
        .if_ready        (1'b1),
        .if_inst         (w_if_inst),
        .if_pc           (w_if_pc),
        .redirect_valid  (1'b0),
        .redirect_target (16'h0000),
        .fetch_count     (w_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: abstract fetch stream position plus memory bookkeeping
    logic [AW-1:0] ref_pc      = RPC;
    logic [15:0]   ref_count   = 16'h0000;
    bit            mem_pending = 1'b0;
    bit            cancel      = 1'b0;
    bit            buffered    = 1'b0;
    bit            prev_rst    = 1'b0;
    logic [AW-1:0] mem_dut_addr = '0;
    int            handoffs    = 0;

    int p_ready = 100;
    int p_if    = 100;
    int p_redir = 0;
    int p_resp  = 100;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return ~a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: inputs and outputs are stable at negedge and
    // describe what the next posedge will do
    always @(negedge clk) begin : mon
        item_t it;
        bit    in_req;
        bit    in_wait;
        if (prev_rst) begin
            check("rst_req_valid", 32'(imem_req_valid), 32'(1'b1));
            check("rst_addr", 32'(imem_addr), 32'(RPC));
            check("rst_if_valid", 32'(if_valid), 32'(1'b0));
            check("rst_fetch_count", 32'(fetch_count), 32'(16'h0000));
            check("rst_if_pc", 32'(if_pc), 32'(16'h0000));
            check("rst_if_inst", 32'(if_inst), 32'(16'h0000));
        end
        if (rst) begin
            ref_pc      = RPC;
            ref_count   = 16'h0000;
            mem_pending = 1'b0;
            cancel      = 1'b0;
            buffered    = 1'b0;
            exp_q.delete();
            prev_rst    = 1'b1;
        end else begin
            prev_rst = 1'b0;
            in_req   = !mem_pending && !buffered;
            in_wait  = mem_pending;
            check("if_valid", 32'(if_valid), 32'(buffered));
            check("req_valid", 32'(imem_req_valid), 32'(in_req));
            if (buffered && exp_q.size() > 0) begin
                check("hold_pc", 32'(if_pc), 32'(exp_q[0].pc));
                check("hold_inst", 32'(if_inst), 32'(exp_q[0].inst));
            end
            if (in_req) begin
                if (!redirect_valid && imem_req_ready) begin
                    check("req_addr", 32'(imem_addr), 32'(ref_pc));
                    mem_pending  = 1'b1;
                    mem_dut_addr = imem_addr;
                    cancel       = 1'b0;
                end
            end else if (in_wait) begin
                if (redirect_valid) cancel = 1'b1;
                if (imem_resp_valid) begin
                    mem_pending = 1'b0;
                    if (!cancel) begin
                        it.pc   = ref_pc;
                        it.inst = mem_word(ref_pc);
                        exp_q.push_back(it);
                        buffered = 1'b1;
                    end
                end
            end else begin
                if (redirect_valid) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_back());
                    buffered = 1'b0;
                end else if (if_ready) begin
                    if (exp_q.size() > 0) begin
                        it = exp_q.pop_front();
                        check("handoff_pc", 32'(if_pc), 32'(it.pc));
                        check("handoff_inst", 32'(if_inst), 32'(it.inst));
                        check("fetch_count", 32'(fetch_count), 32'(ref_count));
                        ref_count = ref_count + 16'd1;
                        ref_pc    = it.pc + 16'd1;
                        handoffs++;
                    end
                    buffered = 1'b0;
                end
            end
            if (redirect_valid) ref_pc = redirect_target;
        end
    end

    // Wrap instance: always-ready memory answering the cycle after acceptance
    initial begin : wrap_mon
        logic [AW-1:0] w_exp;
        logic [AW-1:0] w_hexp;
        logic [AW-1:0] w_last;
        bit            acc;
        w_exp        = 16'hFFFE;
        w_hexp       = 16'hFFFE;
        w_last       = '0;
        w_resp_valid = 1'b0;
        w_resp_data  = '0;
        forever begin
            @(negedge clk);
            acc = 1'b0;
            if (rst) begin
                w_exp  = 16'hFFFE;
                w_hexp = 16'hFFFE;
            end else begin
                if (w_req_valid) begin
                    check("wrap_addr", 32'(w_addr), 32'(w_exp));
                    w_exp  = w_exp + 16'd1;
                    w_last = w_addr;
                    acc    = 1'b1;
                end
                if (w_if_valid) begin
                    check("wrap_if_pc", 32'(w_if_pc), 32'(w_hexp));
                    check("wrap_if_inst", 32'(w_if_inst), 32'(mem_word(w_hexp)));
                    w_hexp = w_hexp + 16'd1;
                end
            end
            @(posedge clk);
            #1;
            w_resp_valid = acc;
            w_resp_data  = mem_word(w_last);
        end
    end

    // Random input pattern for one cycle, shaped by the current knobs
    task automatic drive_cycle();
        redirect_valid  = (int'($urandom_range(99)) < p_redir);
        redirect_target = ($urandom_range(3) == 0) ? AW'(16'hFFFD + 16'($urandom_range(3)))
                                                   : AW'($urandom_range(255));
        imem_req_ready  = (int'($urandom_range(99)) < p_ready);
        if_ready        = (int'($urandom_range(99)) < p_if);
        imem_resp_valid = mem_pending && (int'($urandom_range(99)) < p_resp);
        imem_resp_data  = imem_resp_valid ? mem_word(mem_dut_addr) : DW'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stim
        int n;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Ideal memory and decode: one handoff every three cycles
        p_ready = 100; p_if = 100; p_redir = 0; p_resp = 100;
        run(30);
        check("ideal_handoffs", 32'(handoffs), 32'd10);

        // Decode back-pressure dominant
        p_ready = 70; p_if = 10; p_redir = 0; p_resp = 60;
        run(200);

        // Frequent redirects in every state
        p_ready = 60; p_if = 60; p_redir = 20; p_resp = 40;
        run(400);

        // Reset while a response is outstanding; stale response follows release
        p_redir = 0;
        n = 0;
        while (!mem_pending && n < 200) begin
            drive_cycle();
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!mem_pending) begin
            errors++;
            $display("FAIL reset_setup actual=no_outstanding required=outstanding t=%0t", $time);
        end
        rst             = 1'b1;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 16'hBEEF;
        imem_req_ready  = 1'b0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        @(posedge clk);
        #1;

        // Mixed traffic
        p_ready = 50; p_if = 50; p_redir = 6; p_resp = 40;
        run(2500);

        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        check("progress", 32'(handoffs > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
